// File: rtl/pwm_bank.sv
// N-channel PWM LED driver: one shared period counter, double-buffered duty
// registers behind a valid/ready write port, and a per-channel breathe ramp.
module pwm_bank #(
    parameter int NCH      = 4,
    parameter int W        = 8,
    parameter int RAMP_DIV = 16,
    parameter int CHW      = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_ch,
    input  logic [W-1:0]   wr_duty,
    input  logic           wr_mode,
    output logic           wr_rdy,
    output logic           period_tick,
    output logic [NCH-1:0] pwm_out
);

    localparam int DIVW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [W-1:0]    CNT_LAST = {{(W-1){1'b1}}, 1'b0};
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(RAMP_DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_DOWN = 2'd2;

    logic [W-1:0]    r_cnt;
    logic            r_tick;
    logic            r_rdy;
    logic [DIVW-1:0] r_div;
    logic [NCH-1:0]  r_pwm;
    logic [W-1:0]    r_sduty [NCH];
    logic [NCH-1:0]  r_smode;
    logic [W-1:0]    r_act   [NCH];
    logic [1:0]      r_st    [NCH];

    logic w_cnt_last;
    logic w_step;
    logic w_wr_acc;

    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign w_step     = (r_div == DIV_LAST);
    assign w_wr_acc   = wr_en & r_rdy;

    // Direction flips on the step that reaches an endpoint, so one full
    // breathe cycle is 2*peak steps; a peak dropped below the level clamps.
    function automatic logic [W+1:0] ramp_step(input logic [1:0]   st,
                                               input logic [W-1:0] act,
                                               input logic [W-1:0] peak);
        logic [1:0]   s;
        logic [W-1:0] a;
        s = st;
        a = act;
        if (st == S_UP) begin
            if (act >= peak) begin
                a = peak;
                s = S_DOWN;
            end else begin
                a = act + W'(1);
                if (a >= peak) s = S_DOWN;
            end
        end else if (st == S_DOWN) begin
            if (act == '0) begin
                s = S_UP;
            end else begin
                a = act - W'(1);
                if (a == '0) s = S_UP;
            end
        end
        return {s, a};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_tick  <= 1'b0;
            r_rdy   <= 1'b0;
            r_div   <= '0;
            r_pwm   <= '0;
            r_smode <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_sduty[i] <= '0;
                r_act[i]   <= '0;
                r_st[i]    <= S_IDLE;
            end
        end else begin
            r_cnt  <= w_cnt_last ? '0 : r_cnt + W'(1);
            r_tick <= w_cnt_last;
            r_rdy  <= ~w_cnt_last;
            if (r_tick) r_div <= w_step ? '0 : r_div + DIVW'(1);
            for (int i = 0; i < NCH; i++) begin
                r_pwm[i] <= (r_cnt < r_act[i]);
                // Out-of-range channel indices match no slot and are dropped.
                if (w_wr_acc && (wr_ch == CHW'(i))) begin
                    r_sduty[i] <= wr_duty;
                    r_smode[i] <= wr_mode;
                end
                if (r_tick) begin
                    if (!r_smode[i]) begin
                        r_act[i] <= r_sduty[i];
                        r_st[i]  <= S_IDLE;
                    end else if (r_st[i] == S_IDLE) begin
                        r_act[i] <= '0;
                        r_st[i]  <= S_UP;
                    end else if (w_step) begin
                        {r_st[i], r_act[i]} <= ramp_step(r_st[i], r_act[i], r_sduty[i]);
                    end
                end
            end
        end
    end

    assign wr_rdy      = r_rdy;
    assign period_tick = r_tick;
    assign pwm_out     = r_pwm;

endmodule
